barrett_for_1481: RTL and testbench



---
 rtl/barrett_for_1481_if.sv | 7 +
 rtl/barrett_for_1481.sv | 22 ++
 tb/tb_barrett_for_1481.sv | 82 ++++++++
 3 files changed

// File: rtl/barrett_for_1481_if.sv
// barrett_for_1481_if: operand/residue bundle for the mod-1481 reducer
interface barrett_for_1481_if;
  logic [20:0] din_a;
  logic [10:0] dout_r;
  modport master (output din_a, input dout_r);
  modport slave (input din_a, output dout_r);
endinterface

// File: rtl/barrett_for_1481.sv
// barrett_for_1481: registered Barrett reduction of a 21-bit operand mod 1481
module barrett_for_1481 (
  input  logic                clk,
  input  logic                rst,
  barrett_for_1481_if.slave   io
);
  logic [32:0] p;
  logic [10:0] q_hat;
  logic [21:0] t;
  logic [11:0] r0;
  logic [10:0] dout_d, dout_q;
  always_comb begin
    p = {12'd0, io.din_a} * 33'd2832;
    q_hat = 11'(p >> 22);
    t = {11'd0, q_hat} * 22'd1481;
    // q_hat undershoots by at most one, so r0 < 2*q and one subtraction suffices
    r0 = 12'({1'b0, io.din_a} - t);
    dout_d = r0 >= 12'd1481 ? 11'(r0 - 12'd1481) : r0[10:0];
  end
  always_ff @(posedge clk) dout_q <= rst ? 11'd0 : dout_d;
  assign io.dout_r = dout_q;
endmodule

// File: tb/tb_barrett_for_1481.sv
// tb_barrett_for_1481: directed, table-driven and random checks of the mod-1481 reducer
module tb_barrett_for_1481;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  barrett_for_1481_if bif ();
  barrett_for_1481 dut (.clk(clk), .rst(rst), .io(bif.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] x;
    logic [10:0] r;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic [20:0] x);
    @(negedge clk);
    bif.din_a = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [20:0] x;
    vecs[0] = '{21'd1481, 11'd0};
    vecs[1] = '{21'd1482, 11'd1};
    vecs[2] = '{21'd2961, 11'd1480};
    vecs[3] = '{21'd2962, 11'd0};
    vecs[4] = '{21'd2097096, 11'd0};
    vecs[5] = '{21'd2097151, 11'd55};
    vecs[6] = '{21'd1000000, 11'd325};
    vecs[7] = '{21'd2097095, 11'd1480};
    bif.din_a = 21'd1480;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_hold", int'(bif.dout_r), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", int'(bif.dout_r), 1480);
    for (int i = 0; i <= 1480; i++) begin
      apply(21'(i));
      check("identity", int'(bif.dout_r), i);
    end
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].x);
      check($sformatf("vec%0d", i), int'(bif.dout_r), int'(vecs[i].r));
    end
    apply(21'd1000);
    check("pre_midreset", int'(bif.dout_r), 1000);
    @(negedge clk);
    rst = 1'b1;
    bif.din_a = 21'd1234;
    @(posedge clk);
    #1;
    check("midreset", int'(bif.dout_r), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_resume", int'(bif.dout_r), 1234);
    for (int i = 0; i < 10000; i++) begin
      x = 21'($urandom);
      apply(x);
      check("random", int'(bif.dout_r), int'(x) % 1481);
      if (bif.dout_r > 11'd1480) check("random_range", int'(bif.dout_r), 1480);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
